cache_request_sequencer: RTL

// Master-side driver for the cache interface: takes commands from the trace/command stage upstream and sequences each one onto the
// 4-phase request/valid handshake toward the cache. Captures read data and the evict flag into a one-entry response buffer for the

---
 rtl/cache_request_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_request_sequencer.sv
// Master-side sequencer: turns upstream commands into 4-phase request/valid
// handshakes toward the cache, buffering one response and keeping debug counters.
module cache_request_sequencer #(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32,
  parameter int OPWIDTH      = 3,
  parameter int TIMEOUT      = 255,
  parameter int COUNTWIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPWIDTH-1:0]      cmd_op,
  input  logic                    cmd_is_read,
  input  logic [ADDRESSWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0]    cmd_data,
  output logic [OPWIDTH-1:0]      op_out,
  output logic [ADDRESSWIDTH-1:0] addr_out,
  output logic                    addr_oe,
  output logic [DATAWIDTH-1:0]    d_out,
  output logic                    d_oe,
  input  logic [DATAWIDTH-1:0]    d_in,
  output logic                    request,
  input  logic                    valid,
  input  logic                    evict,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATAWIDTH-1:0]    rsp_data,
  output logic                    rsp_evict,
  output logic [COUNTWIDTH-1:0]   txn_count,
  output logic [COUNTWIDTH-1:0]   evict_count,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [COUNTWIDTH-1:0] CNT_ONE = {{(COUNTWIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [OPWIDTH-1:0]      op_q, op_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0]    dout_q, dout_d;
  logic                    is_read_q, is_read_d;
  logic                    request_q, request_d;
  logic                    addr_oe_q, addr_oe_d;
  logic                    d_oe_q, d_oe_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                    rsp_evict_q, rsp_evict_d;
  logic [COUNTWIDTH-1:0]   txn_q, txn_d;
  logic [COUNTWIDTH-1:0]   evict_cnt_q, evict_cnt_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             phase_q, phase_d;
  logic [15:0]             phase_inc_s;
  logic                    cmd_ready_s;
  logic                    rsp_load_s;

  // A stale acknowledge must fall before the next handshake may open
  assign cmd_ready_s = (state_q == S_IDLE) && !valid;
  assign rsp_load_s  = (state_q == S_REQ) && valid && (!rsp_valid_q || rsp_ready);
  assign phase_inc_s = (phase_q == 16'hFFFF) ? phase_q : phase_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    is_read_d   = is_read_q;
    request_d   = request_q;
    addr_oe_d   = addr_oe_q;
    d_oe_d      = d_oe_q;
    rsp_data_d  = rsp_data_q;
    rsp_evict_d = rsp_evict_q;
    txn_d       = txn_q;
    evict_cnt_d = evict_cnt_q;
    timeout_d   = timeout_q;
    phase_d     = phase_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_s) begin
          op_d      = cmd_op;
          addr_d    = cmd_addr;
          dout_d    = cmd_data;
          is_read_d = cmd_is_read;
          request_d = 1'b1;
          addr_oe_d = 1'b1;
          d_oe_d    = !cmd_is_read;
          phase_d   = 16'd0;
          state_d   = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (rsp_load_s) begin
          rsp_data_d  = is_read_q ? d_in : {DATAWIDTH{1'b0}};
          rsp_evict_d = evict;
          rsp_valid_d = 1'b1;
          request_d   = 1'b0;
          addr_oe_d   = 1'b0;
          d_oe_d      = 1'b0;
          phase_d     = 16'd0;
          state_d     = S_ACK;
        end else begin
          // Timeout is only reported; the handshake must still complete
          phase_d = phase_inc_s;
          if (phase_inc_s >= TIMEOUT_C) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end
      end
      S_ACK: begin
        if (!valid) begin
          txn_d       = txn_q + CNT_ONE;
          evict_cnt_d = evict_cnt_q + {{(COUNTWIDTH-1){1'b0}}, rsp_evict_q};
          state_d     = S_IDLE;
        end else begin
          phase_d = phase_inc_s;
          if (phase_inc_s >= TIMEOUT_C) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        request_d = 1'b0;
        addr_oe_d = 1'b0;
        d_oe_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= {OPWIDTH{1'b0}};
      addr_q      <= {ADDRESSWIDTH{1'b0}};
      dout_q      <= {DATAWIDTH{1'b0}};
      is_read_q   <= 1'b0;
      request_q   <= 1'b0;
      addr_oe_q   <= 1'b0;
      d_oe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DATAWIDTH{1'b0}};
      rsp_evict_q <= 1'b0;
      txn_q       <= {COUNTWIDTH{1'b0}};
      evict_cnt_q <= {COUNTWIDTH{1'b0}};
      timeout_q   <= 1'b0;
      phase_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      is_read_q   <= is_read_d;
      request_q   <= request_d;
      addr_oe_q   <= addr_oe_d;
      d_oe_q      <= d_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_evict_q <= rsp_evict_d;
      txn_q       <= txn_d;
      evict_cnt_q <= evict_cnt_d;
      timeout_q   <= timeout_d;
      phase_q     <= phase_d;
    end
  end

  assign cmd_ready   = cmd_ready_s;
  assign op_out      = op_q;
  assign addr_out    = addr_q;
  assign addr_oe     = addr_oe_q;
  assign d_out       = dout_q;
  assign d_oe        = d_oe_q;
  assign request     = request_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_evict   = rsp_evict_q;
  assign txn_count   = txn_q;
  assign evict_count = evict_cnt_q;
  assign timeout_err = timeout_q;

endmodule
